// File: rtl/disp_btn_ctrl.sv
// rtl/disp_btn_ctrl.sv - synchronise and debounce three push-buttons into ch/pc toggles and a step pulse
module disp_btn_ctrl #(
    parameter int   CNT_W   = 16,
    parameter logic CH_INIT = 1'b0,
    parameter logic PC_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ch,
    input  logic       btn_pc,
    input  logic       btn_step,
    output logic       ch,
    output logic       pc,
    output logic       step,
    output logic [2:0] btn_lvl
);

    typedef enum logic [1:0] {IDLE, PRS_WAIT, PRESSED, REL_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0] raw;
    logic [2:0] press;

    assign raw = {btn_step, btn_pc, btn_ch};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic             q1;
        logic             q2;
        logic             lvl_q;
        state_t           state;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q1 <= 1'b0;
                q2 <= 1'b0;
            end else begin
                q1 <= raw[i];
                q2 <= q1;
            end
        end

        // Press is decoded combinationally so the downstream toggle lands on the same edge as PRESSED.
        assign press[i]   = (state == PRS_WAIT) && q2 && (cnt == CNT_MAX);
        assign btn_lvl[i] = lvl_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                cnt   <= '0;
                lvl_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (q2) begin
                            state <= PRS_WAIT;
                            cnt   <= '0;
                        end
                    end
                    PRS_WAIT: begin
                        if (!q2) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_MAX) begin
                            state <= PRESSED;
                            cnt   <= '0;
                            lvl_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!q2) begin
                            state <= REL_WAIT;
                            cnt   <= '0;
                        end
                    end
                    REL_WAIT: begin
                        if (q2) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == CNT_MAX) begin
                            state <= IDLE;
                            cnt   <= '0;
                            lvl_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        lvl_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch   <= CH_INIT;
            pc   <= PC_INIT;
            step <= 1'b0;
        end else begin
            if (press[0]) ch <= ~ch;
            if (press[1]) pc <= ~pc;
            step <= press[2];
        end
    end

endmodule
